// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry, LSB first.
// Accepts operands on start and returns sum, carry-out and signed overflow with a done pulse.
module serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_cnext;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   // Full-adder cell on the current LSBs
   assign w_s     = r_sa[0] ^ r_sb[0] ^ r_carry;
   assign w_cnext = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

   // A new request is accepted whenever no operation is running (IDLE or DONE)
   assign w_load = start && (r_state != S_RUN);
   assign w_last = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_res_nxt            = r_res >> 1;
      w_res_nxt[WIDTH-1]   = w_s;
   end

   // State register; busy/done are registered alongside it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state
   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      if (w_state_nxt == S_RUN)  w_busy_nxt = 1'b1;
      if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
   end

   // Serial datapath; subtraction is A + ~B + 1 with the +1 as the initial carry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa      <= '0;
         r_sb      <= '0;
         r_res     <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (w_load) begin
         r_sa    <= a;
         r_sb    <= sub ? ~b : b;
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_sa    <= r_sa >> 1;
         r_sb    <= r_sb >> 1;
         r_res   <= w_res_nxt;
         r_carry <= w_cnext;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            sum       <= w_res_nxt;
            carry_out <= w_cnext;
            overflow  <= r_carry ^ w_cnext;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH 8, 1 and 16.
// Expected results are hand-computed or derived from an arithmetic reference.
module tb_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       st8, sb8, busy8, done8, co8, ov8;
   logic [7:0] a8, b8, sum8;
   logic       st1, sb1, busy1, done1, co1, ov1;
   logic [0:0] a1, b1, sum1;
   logic        st16, sb16, busy16, done16, co16, ov16;
   logic [15:0] a16, b16, sum16;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] prev8 = 8'h00;

   serial_addsub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8));

   serial_addsub #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1));

   serial_addsub #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(st16), .sub(sb16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16), .overflow(ov16));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge with the 8-bit DUT idle or in its done cycle
   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                      input logic [7:0] es, input logic ec, input logic eo);
      a8 = ia; b8 = ib; sb8 = isub; st8 = 1'b1;
      @(posedge clk);
      #1 st8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("busy8_run", 32'(busy8), 32'd1);
         check("done8_early", 32'(done8), 32'd0);
         check("sum8_held", 32'(sum8), 32'(prev8));
         @(posedge clk);
      end
      @(negedge clk);
      check("done8", 32'(done8), 32'd1);
      check("busy8_done", 32'(busy8), 32'd0);
      check("sum8", 32'(sum8), 32'(es));
      check("co8", 32'(co8), 32'(ec));
      check("ov8", 32'(ov8), 32'(eo));
      prev8 = es;
   endtask

   initial begin
      rst = 1'b1;
      st8 = 1'b1; sb8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      st1 = 1'b0; sb1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      st16 = 1'b0; sb16 = 1'b0; a16 = '0; b16 = '0;

      // Reset overrides start
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum", 32'(sum8), 32'd0);
      check("rst_co", 32'(co8), 32'd0);
      check("rst_ov", 32'(ov8), 32'd0);
      rst = 1'b0; st8 = 1'b0;
      @(negedge clk);
      check("rst_nostart", 32'(busy8), 32'd0);

      op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      // Back-to-back start issued during the done cycle
      op8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
      @(negedge clk);
      check("done8_pulse", 32'(done8), 32'd0);
      check("busy8_idle", 32'(busy8), 32'd0);
      check("sum8_stable", 32'(sum8), 32'h07);

      // Start pulses while busy must be ignored
      a8 = 8'h11; b8 = 8'h22; sb8 = 1'b0; st8 = 1'b1;
      @(posedge clk);
      #1 st8 = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         check("busy8_prot", 32'(busy8), 32'd1);
         if (cyc == 3 || cyc == 5) begin
            a8 = 8'hFF; b8 = 8'hFF; sb8 = 1'b1; st8 = 1'b1;
         end else begin
            st8 = 1'b0;
         end
      end
      @(negedge clk);
      check("prot_done", 32'(done8), 32'd1);
      check("prot_sum", 32'(sum8), 32'h33);
      check("prot_co", 32'(co8), 32'd0);
      check("prot_ov", 32'(ov8), 32'd0);

      // Reset mid-run aborts with no done pulse
      a8 = 8'h40; b8 = 8'h40; sb8 = 1'b0; st8 = 1'b1;
      @(posedge clk);
      #1 st8 = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         if (cyc == 4) rst = 1'b1;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_done", 32'(done8), 32'd0);
         check("abort_busy", 32'(busy8), 32'd0);
      end
      check("abort_sum", 32'(sum8), 32'd0);
      check("abort_co", 32'(co8), 32'd0);
      check("abort_ov", 32'(ov8), 32'd0);
      prev8 = 8'h00;

      // WIDTH=1 full-adder truth table, latency 2
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         logic ia, ib, is, es, ec, eo;
         v = 3'(i);
         ia = v[2]; ib = v[1]; is = v[0];
         es = ia ^ ib;
         ec = is ? (ia | ~ib) : (ia & ib);
         eo = is ? (~ia & ib) : (ia & ib);
         a1 = ia; b1 = ib; sb1 = is; st1 = 1'b1;
         @(posedge clk);
         #1 st1 = 1'b0;
         @(negedge clk);
         check("w1_busy", 32'(busy1), 32'd1);
         check("w1_early", 32'(done1), 32'd0);
         @(negedge clk);
         check("w1_done", 32'(done1), 32'd1);
         check("w1_sum", 32'(sum1), 32'(es));
         check("w1_co", 32'(co1), 32'(ec));
         check("w1_ov", 32'(ov1), 32'(eo));
      end

      // WIDTH=16 random operands against an arithmetic reference
      for (int n = 0; n < 1000; n++) begin
         logic [15:0] ia, ib, es;
         logic        is, ec, eo;
         logic [16:0] wide;
         int t;
         ia = 16'($urandom);
         ib = 16'($urandom);
         is = 1'($urandom_range(0, 1));
         if (is) begin
            es = ia - ib;
            ec = (ia >= ib);
            eo = (ia[15] != ib[15]) && (es[15] != ia[15]);
         end else begin
            wide = 17'(ia) + 17'(ib);
            es = wide[15:0];
            ec = wide[16];
            eo = (ia[15] == ib[15]) && (es[15] != ia[15]);
         end
         a16 = ia; b16 = ib; sb16 = is; st16 = 1'b1;
         @(posedge clk);
         #1 st16 = 1'b0;
         t = 0;
         while (!done16 && t < 40) begin
            @(negedge clk);
            t++;
         end
         check("w16_lat", 32'(t), 32'd17);
         check("w16_sum", 32'(sum16), 32'(es));
         check("w16_co", 32'(co16), 32'(ec));
         check("w16_ov", 32'(ov16), 32'(eo));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor: the multi-bit, sequential successor to our combinational half adder. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It returns sum, carry-out and signed overflow with a one-cycle done pulse. It sits behind the tile I/O wrapper, which drives operands and strobes from ui_in/uio_in and maps results to uo_out.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk        input   1      system clock, all logic on rising edge
rst        input   1      synchronous reset, active-high
start      input   1      request; sampled only when busy=0
sub        input   1      0 = A+B, 1 = A-B; sampled with start
a          input   WIDTH  operand A; sampled with start
b          input   WIDTH  operand B; sampled with start
busy       output  1      operation in progress
done       output  1      one-cycle pulse; results valid
sum        output  WIDTH  result (A+B or A-B, modulo 2^WIDTH)
carry_out  output  1      carry from MSB; for sub, 1 = no borrow (A>=B unsigned)
overflow   output  1      two's-complement signed overflow

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with rst=1, the FSM goes to IDLE. busy, done, sum, carry_out and overflow all become 0, and internal shift registers, carry and bit counter clear. rst overrides start.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, and outputs hold their last result. On an edge with start=1:
  - load shift_a<=a and shift_b<=(sub ? ~b : b);
  - set carry<=sub and count<=0;
  - latch sub internally;
  - go to RUN.
- RUN: busy=1, done=0. Each edge:
  - s = shift_a[0]^shift_b[0]^carry; carry <= majority(shift_a[0], shift_b[0], carry);
  - shift_a and shift_b shift right by 1;
  - s shifts into result register at the MSB, with the register shifting right;
  - count increments.
- On the edge processing bit WIDTH-1, capture carry_in_msb (the carry into the MSB) and go to DONE. The sum, carry_out and overflow registers update on this same edge. overflow = carry_in_msb ^ final carry.
- DONE: busy=0, done=1 for exactly one cycle. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted; new operands loaded as in IDLE).
- Latency: start sampled at edge k; busy=1 in cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- Results (sum, carry_out, overflow) change only on the transition into DONE or on reset. They are stable from done until the next completion. During RUN the exposed sum output keeps the previous result; the partial result lives in an internal register.
- start while busy=1 is ignored; no queuing. Changes to a, b or sub during RUN have no effect.
- rst asserted mid-RUN aborts the operation: no done pulse, outputs cleared to 0.
- WIDTH=1 degenerates to a registered full adder:
  - sub=0: sum=a^b, carry_out=a&b (half-adder equivalent);
  - overflow = carry_in_msb ^ carry_out, with carry_in_msb = sub.
- Counter width is clog2(WIDTH)+1. No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1, a=0xFF, b=0xFF -> busy=0, done=0, sum=0x00, carry_out=0, overflow=0; no operation starts.
- Add with signed overflow (WIDTH=8): a=0x5A, b=0x33, sub=0, start at edge k -> busy=1 cycles k+1..k+8; done=1 only at k+9; sum=0x8D, carry_out=0, overflow=1.
- Add wrap: a=0xFF, b=0x01, sub=0 -> sum=0x00, carry_out=1, overflow=0. Subtract with borrow: a=0x10, b=0x20, sub=1 -> sum=0xF0, carry_out=0, overflow=0.
- Signed-underflow subtract: a=0x80, b=0x01, sub=1 -> sum=0x7F, carry_out=1, overflow=1. Then start=1 during the done cycle with a=0x03, b=0x04, sub=0 -> new done exactly 9 cycles later with sum=0x07, and the prior result held until then.
- Protocol: pulse start with new operands at cycles k+3 and k+5 of a running op -> ignored, result unchanged. Assert rst at cycle k+4 -> no done pulse, all outputs 0, returns to IDLE.
- Parameter sweep: WIDTH=1, all 8 (a,b,sub) combinations -> match the full-adder truth table, latency of 2 cycles. WIDTH=16 with 1000 random operand pairs -> match the reference model {carry,sum} = a ± b, with overflow checked by the sign rule.
